packet2_axis: RTL and testbench



---
 rtl/packet2_axis_if.sv | 22 ++
 rtl/packet2_axis.sv | 197 +++++++++++++++++++
 tb/tb_packet2_axis.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/packet2_axis_if.sv
// AXI4-Stream beat channel between the Aurora packetizer and its downstream consumer.
// The master drives valid/data/last; the slave returns ready.
interface packet2_axis_if;
    logic        TVALID;
    logic        TREADY;
    logic        TLAST;
    logic [31:0] TDATA;

    modport master (
        output TVALID,
        output TLAST,
        output TDATA,
        input  TREADY
    );

    modport slave (
        input  TVALID,
        input  TLAST,
        input  TDATA,
        output TREADY
    );
endinterface

// File: rtl/packet2_axis.sv
// Aurora transmit packetizer: serializes {header, data words} onto AXI4-Stream, with a
// one-entry pending slot so a queued packet follows the current one with no idle beat.
module packet2_axis #(
    parameter int MAGIC_WIDTH     = 16,
    parameter int MAGIC_START_BIT = 16,
    parameter int INDEX_WIDTH     = 5,
    parameter int INDEX_START_BIT = 10,
    parameter int NUM_DATA_WORDS  = 1
) (
    input  logic                         auroraClk,
    input  logic                         auroraReset,
    input  logic [MAGIC_WIDTH-1:0]       headerMagic,
    input  logic                         packetStrobe,
    input  logic [INDEX_WIDTH-1:0]       packetIndex,
    input  logic [32*NUM_DATA_WORDS-1:0] packetData,
    packet2_axis_if.master               axis,
    output logic                         busy,
    output logic                         sentStrobe,
    output logic                         dropStrobe
);

    if (INDEX_START_BIT + INDEX_WIDTH - 1 > MAGIC_START_BIT - 1) begin : g_bad_layout
        $error("packet2_axis: index field overlaps magic field");
    end
    if (NUM_DATA_WORDS < 1) begin : g_bad_words
        $error("packet2_axis: NUM_DATA_WORDS must be at least 1");
    end

    localparam int                CW       = $clog2(NUM_DATA_WORDS + 1);
    localparam int                DW       = 32 * NUM_DATA_WORDS;
    localparam logic [CW-1:0]     LAST_CNT = CW'(NUM_DATA_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA} state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_word_cnt;
    logic                   r_tvalid;
    logic                   r_tlast;
    logic [31:0]            r_tdata;
    logic                   r_busy;
    logic                   r_sent;
    logic                   r_drop;

    logic                   r_act_full;
    logic [MAGIC_WIDTH-1:0] r_act_magic;
    logic [INDEX_WIDTH-1:0] r_act_index;
    logic [DW-1:0]          r_act_data;
    logic                   r_pend_full;
    logic [MAGIC_WIDTH-1:0] r_pend_magic;
    logic [INDEX_WIDTH-1:0] r_pend_index;
    logic [DW-1:0]          r_pend_data;

    logic                   w_hs;
    logic                   w_last_hs;
    logic                   w_act_from_pend;
    logic                   w_act_from_req;
    logic                   w_new_act;
    logic                   w_load_pend;
    logic                   w_drop;
    logic                   w_act_full_nxt;
    logic                   w_pend_full_nxt;
    logic [MAGIC_WIDTH-1:0] w_new_magic;
    logic [INDEX_WIDTH-1:0] w_new_index;
    logic [31:0]            w_new_hdr;
    logic [CW-1:0]          w_next_cnt;
    logic [31:0]            w_next_word;

    assign axis.TVALID = r_tvalid;
    assign axis.TLAST  = r_tlast;
    assign axis.TDATA  = r_tdata;
    assign busy        = r_busy;
    assign sentStrobe  = r_sent;
    assign dropStrobe  = r_drop;

    // Slot admission: the active slot frees on the last-word handshake, so a request in that
    // same cycle can still be taken without a drop.
    always_comb begin
        w_hs            = r_tvalid && axis.TREADY;
        w_last_hs       = (r_state == S_DATA) && w_hs && (r_word_cnt == LAST_CNT);
        w_act_from_pend = w_last_hs && r_pend_full;
        w_act_from_req  = packetStrobe && !w_act_from_pend && (!r_act_full || w_last_hs);
        w_new_act       = w_act_from_pend || w_act_from_req;
        w_load_pend     = packetStrobe && !w_act_from_req && (!r_pend_full || w_act_from_pend);
        w_drop          = packetStrobe && !w_act_from_req && !w_load_pend;
        w_act_full_nxt  = w_new_act || (r_act_full && !w_last_hs);
        w_pend_full_nxt = w_load_pend || (r_pend_full && !w_act_from_pend);
    end

    always_comb begin
        w_new_magic = headerMagic;
        w_new_index = packetIndex;
        if (w_act_from_pend) begin
            w_new_magic = r_pend_magic;
            w_new_index = r_pend_index;
        end
        w_new_hdr = '0;
        w_new_hdr[MAGIC_START_BIT +: MAGIC_WIDTH] = w_new_magic;
        w_new_hdr[INDEX_START_BIT +: INDEX_WIDTH] = w_new_index;
    end

    always_comb begin
        w_next_cnt  = r_word_cnt + CW'(1);
        w_next_word = '0;
        for (int j = 0; j < NUM_DATA_WORDS; j++) begin
            if (int'(w_next_cnt) == j) begin
                w_next_word = r_act_data[32*j +: 32];
            end
        end
    end

    always_ff @(posedge auroraClk) begin
        if (auroraReset) begin
            r_state      <= S_IDLE;
            r_word_cnt   <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_tdata      <= '0;
            r_busy       <= 1'b0;
            r_sent       <= 1'b0;
            r_drop       <= 1'b0;
            r_act_full   <= 1'b0;
            r_act_magic  <= '0;
            r_act_index  <= '0;
            r_act_data   <= '0;
            r_pend_full  <= 1'b0;
            r_pend_magic <= '0;
            r_pend_index <= '0;
            r_pend_data  <= '0;
        end else begin
            r_sent     <= w_last_hs;
            r_drop     <= w_drop;
            r_busy     <= w_act_full_nxt || w_pend_full_nxt;
            r_act_full <= w_act_full_nxt;

            if (w_act_from_pend) begin
                r_act_magic <= r_pend_magic;
                r_act_index <= r_pend_index;
                r_act_data  <= r_pend_data;
            end else if (w_act_from_req) begin
                r_act_magic <= headerMagic;
                r_act_index <= packetIndex;
                r_act_data  <= packetData;
            end

            r_pend_full <= w_pend_full_nxt;
            if (w_load_pend) begin
                r_pend_magic <= headerMagic;
                r_pend_index <= packetIndex;
                r_pend_data  <= packetData;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (w_new_act) begin
                        r_state  <= S_HEADER;
                        r_tvalid <= 1'b1;
                        r_tlast  <= 1'b0;
                        r_tdata  <= w_new_hdr;
                    end
                end
                S_HEADER: begin
                    if (w_hs) begin
                        r_state    <= S_DATA;
                        r_word_cnt <= '0;
                        r_tdata    <= r_act_data[31:0];
                        r_tlast    <= (LAST_CNT == '0);
                    end
                end
                S_DATA: begin
                    if (w_last_hs) begin
                        r_word_cnt <= '0;
                        if (w_new_act) begin
                            r_state  <= S_HEADER;
                            r_tvalid <= 1'b1;
                            r_tlast  <= 1'b0;
                            r_tdata  <= w_new_hdr;
                        end else begin
                            r_state  <= S_IDLE;
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                            r_tdata  <= '0;
                        end
                    end else if (w_hs) begin
                        r_word_cnt <= w_next_cnt;
                        r_tdata    <= w_next_word;
                        r_tlast    <= (w_next_cnt == LAST_CNT);
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_tvalid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_packet2_axis.sv
// Bench for packet2_axis: a queue-of-beats / slot-occupancy model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_packet2_axis;
    localparam int N  = 4;
    localparam int MS = 16;
    localparam int IS = 10;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [15:0]    magic = '0;
    logic           strobe = 1'b0;
    logic [4:0]     idx = '0;
    logic [32*N-1:0] pdata = '0;
    logic           busy;
    logic           sent;
    logic           drop;

    packet2_axis_if axis ();

    packet2_axis #(
        .MAGIC_WIDTH    (16),
        .MAGIC_START_BIT(MS),
        .INDEX_WIDTH    (5),
        .INDEX_START_BIT(IS),
        .NUM_DATA_WORDS (N)
    ) dut (
        .auroraClk   (clk),
        .auroraReset (rst),
        .headerMagic (magic),
        .packetStrobe(strobe),
        .packetIndex (idx),
        .packetData  (pdata),
        .axis        (axis),
        .busy        (busy),
        .sentStrobe  (sent),
        .dropStrobe  (drop)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  failures = 0;
    bit  started = 0;
    int  n_sent = 0;
    int  n_drop = 0;

    logic [32:0] exp_q[$];
    int          occ = 0;
    bit          exp_sent = 0;
    bit          exp_drop = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: packets are a FIFO of expected beats; at most two packets may be held.
    always @(negedge clk) begin
        bit          mv;
        bit          hs;
        bit          last;
        int          free;
        logic [31:0] hdr;
        if (started) begin
            mv = (occ != 0);
            chk("tvalid", 32'(axis.TVALID), 32'(mv));
            chk("busy", 32'(busy), 32'(mv));
            chk("sentStrobe", 32'(sent), 32'(exp_sent));
            chk("dropStrobe", 32'(drop), 32'(exp_drop));
            if (sent === 1'b1) n_sent++;
            if (drop === 1'b1) n_drop++;
            if (mv) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL beat_queue: got beat %h expected none", axis.TDATA);
                end else begin
                    chk("tdata", axis.TDATA, exp_q[0][31:0]);
                    chk("tlast", 32'(axis.TLAST), 32'(exp_q[0][32]));
                end
            end
            if (prev_stall) begin
                chk("stall_tvalid", 32'(axis.TVALID), 32'd1);
                chk("stall_tdata", axis.TDATA, prev_data);
                chk("stall_tlast", 32'(axis.TLAST), 32'(prev_last));
            end
            prev_stall = mv && (axis.TREADY !== 1'b1) && !rst;
            prev_data  = axis.TDATA;
            prev_last  = axis.TLAST;
            if (rst) begin
                exp_q.delete();
                occ      = 0;
                exp_sent = 0;
                exp_drop = 0;
            end else begin
                hs   = mv && (axis.TREADY === 1'b1);
                last = hs && (exp_q.size() > 0) && exp_q[0][32];
                if (hs && exp_q.size() > 0) void'(exp_q.pop_front());
                exp_sent = last;
                exp_drop = 0;
                free     = occ - (last ? 1 : 0);
                if (strobe) begin
                    if (free < 2) begin
                        hdr = (32'(magic) << MS) | (32'(idx) << IS);
                        exp_q.push_back({1'b0, hdr});
                        for (int j = 0; j < N; j++) exp_q.push_back({j == N - 1, pdata[32*j +: 32]});
                        free++;
                    end else begin
                        exp_drop = 1;
                    end
                end
                occ = free;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_fields();
        magic = 16'($urandom);
        idx   = 5'($urandom);
        for (int j = 0; j < N; j++) pdata[32*j +: 32] = $urandom;
    endtask

    task automatic send_rnd();
        rnd_fields();
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (axis.TVALID !== 1'b0 && k < budget) begin
            tick();
            k++;
        end
        tick();
        checks++;
        if (k >= budget) begin
            failures++;
            $display("FAIL wait_idle: got still valid after %0d cycles expected idle", k);
        end
    endtask

    initial begin
        int s0;
        int d0;
        int beats;
        int vcount;
        int runs;
        int k;
        bit pv;
        axis.TREADY = 1'b0;
        @(posedge clk);
        #1;
        started = 1;
        tick();
        tick();
        chk("reset_tvalid", 32'(axis.TVALID), 32'd0);
        chk("reset_tlast", 32'(axis.TLAST), 32'd0);
        chk("reset_tdata", axis.TDATA, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Single packet, ready held high.
        axis.TREADY = 1'b1;
        magic = 16'hA5A5;
        idx   = 5'd3;
        pdata = {32'h44444444, 32'h33333333, 32'h22222222, 32'hDEADBEEF};
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        chk("lit_hdr_valid", 32'(axis.TVALID), 32'd1);
        chk("lit_hdr", axis.TDATA, 32'hA5A50C00);
        tick();
        chk("lit_word0", axis.TDATA, 32'hDEADBEEF);
        chk("lit_word0_last", 32'(axis.TLAST), 32'd0);
        tick();
        tick();
        tick();
        chk("lit_word3", axis.TDATA, 32'h44444444);
        chk("lit_word3_last", 32'(axis.TLAST), 32'd1);
        tick();
        chk("lit_sent", 32'(sent), 32'd1);
        chk("lit_idle", 32'(axis.TVALID), 32'd0);

        // Random backpressure on one packet.
        send_rnd();
        beats = 0;
        k = 0;
        while (axis.TVALID === 1'b1 && k < 200) begin
            axis.TREADY = 1'($urandom_range(0, 1));
            if (axis.TREADY) beats++;
            tick();
            k++;
        end
        chk("stall_beats", 32'(beats), 32'(N + 1));
        axis.TREADY = 1'b1;
        tick();

        // Two strobes two cycles apart: one contiguous run of valid beats.
        s0 = n_sent;
        d0 = n_drop;
        send_rnd();
        vcount = 0;
        runs = 0;
        pv = 0;
        for (int i = 0; i < 20; i++) begin
            if (axis.TVALID === 1'b1) begin
                vcount++;
                if (!pv) runs++;
            end
            pv = (axis.TVALID === 1'b1);
            if (i == 1) rnd_fields();
            strobe = (i == 1);
            tick();
        end
        chk("b2b_beats", 32'(vcount), 32'(2 * (N + 1)));
        chk("b2b_runs", 32'(runs), 32'd1);
        chk("b2b_sent", 32'(n_sent - s0), 32'd2);
        chk("b2b_drop", 32'(n_drop - d0), 32'd0);

        // Three strobes with ready low: the third is discarded.
        s0 = n_sent;
        d0 = n_drop;
        axis.TREADY = 1'b0;
        send_rnd();
        send_rnd();
        send_rnd();
        tick();
        tick();
        chk("full_drop", 32'(n_drop - d0), 32'd1);
        axis.TREADY = 1'b1;
        wait_idle(100);
        chk("full_sent", 32'(n_sent - s0), 32'd2);

        // Strobe coinciding with the last-word handshake while pending is full.
        s0 = n_sent;
        d0 = n_drop;
        axis.TREADY = 1'b0;
        send_rnd();
        send_rnd();
        axis.TREADY = 1'b1;
        k = 0;
        while (!(axis.TVALID === 1'b1 && axis.TLAST === 1'b1) && k < 50) begin
            tick();
            k++;
        end
        chk("lasths_found", 32'(k < 50), 32'd1);
        send_rnd();
        wait_idle(100);
        chk("lasths_drop", 32'(n_drop - d0), 32'd0);
        chk("lasths_sent", 32'(n_sent - s0), 32'd3);

        // Reset mid-data, with a strobe in the reset cycle that must be ignored.
        send_rnd();
        tick();
        rst = 1'b1;
        rnd_fields();
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        rst = 1'b0;
        chk("rst_tvalid", 32'(axis.TVALID), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick();
        chk("rst_ignored", 32'(axis.TVALID), 32'd0);
        magic = 16'h1234;
        idx   = 5'd31;
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        chk("rst_fresh_hdr", axis.TDATA, 32'h12347C00);
        chk("rst_fresh_valid", 32'(axis.TVALID), 32'd1);
        wait_idle(100);

        // Random traffic and backpressure.
        for (int i = 0; i < 3000; i++) begin
            rnd_fields();
            strobe = ($urandom_range(0, 3) == 0);
            axis.TREADY = 1'($urandom_range(0, 1));
            tick();
        end
        strobe = 1'b0;
        axis.TREADY = 1'b1;
        wait_idle(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
